// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_pkg
//  Description : Shared RV32I decode constants: opcodes, ALU operation
//                encoding, ex_ctrl bit positions, decoded bundle type and
//                the decode FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    // INST_SIZE: instruction, data and address width
    localparam int c_xlen   = 32;
    localparam int c_nregs  = 32;
    localparam int c_reg_aw = 5;

    // RV32I major opcodes
    localparam logic [6:0] c_op_lui      = 7'b0110111;
    localparam logic [6:0] c_op_auipc    = 7'b0010111;
    localparam logic [6:0] c_op_jal      = 7'b1101111;
    localparam logic [6:0] c_op_jalr     = 7'b1100111;
    localparam logic [6:0] c_op_branch   = 7'b1100011;
    localparam logic [6:0] c_op_load     = 7'b0000011;
    localparam logic [6:0] c_op_store    = 7'b0100011;
    localparam logic [6:0] c_op_opimm    = 7'b0010011;
    localparam logic [6:0] c_op_op       = 7'b0110011;
    localparam logic [6:0] c_op_misc_mem = 7'b0001111;
    localparam logic [6:0] c_op_system   = 7'b1110011;

    // ALU operation encoding shared with execute
    localparam logic [3:0] c_alu_add   = 4'd0;
    localparam logic [3:0] c_alu_sub   = 4'd1;
    localparam logic [3:0] c_alu_sll   = 4'd2;
    localparam logic [3:0] c_alu_slt   = 4'd3;
    localparam logic [3:0] c_alu_sltu  = 4'd4;
    localparam logic [3:0] c_alu_xor   = 4'd5;
    localparam logic [3:0] c_alu_srl   = 4'd6;
    localparam logic [3:0] c_alu_sra   = 4'd7;
    localparam logic [3:0] c_alu_or    = 4'd8;
    localparam logic [3:0] c_alu_and   = 4'd9;
    localparam logic [3:0] c_alu_passb = 4'd10;

    // ex_ctrl = {src_imm, mem_rd, mem_wr, reg_wr, branch, jump, illegal}
    localparam int c_ctrl_src_imm = 6;
    localparam int c_ctrl_mem_rd  = 5;
    localparam int c_ctrl_mem_wr  = 4;
    localparam int c_ctrl_reg_wr  = 3;
    localparam int c_ctrl_branch  = 2;
    localparam int c_ctrl_jump    = 1;
    localparam int c_ctrl_illegal = 0;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    // Decoded bundle handed to execute; all-zero is the bubble
    typedef struct packed {
        logic                valid;
        logic [c_xlen-1:0]   pc;
        logic [c_xlen-1:0]   rs1_val;
        logic [c_xlen-1:0]   rs2_val;
        logic [c_xlen-1:0]   imm;
        logic [c_reg_aw-1:0] rs1;
        logic [c_reg_aw-1:0] rs2;
        logic [c_reg_aw-1:0] rd;
        logic [3:0]          alu_op;
        logic [2:0]          funct3;
        logic [6:0]          ctrl;
    } bundle_t;

    // funct3/funct7[5] to ALU op; funct7[5] selects SUB only for register ops
    function automatic logic [3:0] alu_op_decode(
        input logic [2:0] funct3,
        input logic       funct7_b5,
        input logic       is_reg_op
    );
        logic [3:0] op;
        case (funct3)
            3'b000:  op = (is_reg_op && funct7_b5) ? c_alu_sub : c_alu_add;
            3'b001:  op = c_alu_sll;
            3'b010:  op = c_alu_slt;
            3'b011:  op = c_alu_sltu;
            3'b100:  op = c_alu_xor;
            3'b101:  op = funct7_b5 ? c_alu_sra : c_alu_srl;
            3'b110:  op = c_alu_or;
            default: op = c_alu_and;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_reg_file
//  Description : 2-read / 1-write architectural register file, x0 reads 0.
//                Macro DECODE_WB_BYPASS_EN: a read of the register being
//                written this cycle returns the write data (write-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_reg_file
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = c_xlen,
    parameter int NREGS = c_nregs
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_reg_aw-1:0] rs1_idx_i,
    input  logic [c_reg_aw-1:0] rs2_idx_i,
    output logic [XLEN-1:0]     rs1_val_o,
    output logic [XLEN-1:0]     rs2_val_o,
    input  logic                we_i,
    input  logic [c_reg_aw-1:0] wr_idx_i,
    input  logic [XLEN-1:0]     wr_data_i
);

    logic [XLEN-1:0] r_regs_q [NREGS];

    // Storage: cleared on reset, writes to x0 dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs_q[i] <= '0;
            end
        end else if (we_i && (wr_idx_i != '0)) begin
            r_regs_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Combinational read ports, optional same-cycle write-through
    always_comb begin
        rs1_val_o = r_regs_q[rs1_idx_i];
        rs2_val_o = r_regs_q[rs2_idx_i];
`ifdef DECODE_WB_BYPASS_EN
        if (we_i && (wr_idx_i != '0) && (wr_idx_i == rs1_idx_i)) rs1_val_o = wr_data_i;
        if (we_i && (wr_idx_i != '0) && (wr_idx_i == rs2_idx_i)) rs2_val_o = wr_data_i;
`endif
        if (rs1_idx_i == '0) rs1_val_o = '0;
        if (rs2_idx_i == '0) rs2_val_o = '0;
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : RV32I decode. Decodes instr_d, reads the register file,
//                stalls fetch on load-use, squashes the wrong path after a
//                redirect and registers a bundle for execute.
//                Macro DECODE_WB_BYPASS_EN enables register-file write-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = c_xlen,
    parameter int NREGS = c_nregs
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_d,
    input  logic [XLEN-1:0] pc_de,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_f,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_ctrl
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1_fld;
    logic [4:0]      w_rs2_fld;
    logic [4:0]      w_rd_fld;
    logic            w_bubble;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic [4:0]      w_rs1_idx;
    logic [4:0]      w_rs2_idx;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_load_use;
    logic            w_stall_f;
    bundle_t         w_dec;
    bundle_t         r_bundle_q;
    bundle_t         r_bundle_d;
    state_e          r_state_q;
    state_e          r_state_d;

    assign w_opcode  = instr_d[6:0];
    assign w_funct3  = instr_d[14:12];
    assign w_rs1_fld = instr_d[19:15];
    assign w_rs2_fld = instr_d[24:20];
    assign w_rd_fld  = instr_d[11:7];
    assign w_bubble  = (instr_d == '0);

    // Which source registers the incoming instruction really reads
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        if (!w_bubble) begin
            case (w_opcode)
                c_op_jalr, c_op_load, c_op_opimm: w_use_rs1 = 1'b1;
                c_op_branch, c_op_store, c_op_op: begin
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Unused source fields are reported as x0 so execute never forwards on them
    assign w_rs1_idx = w_use_rs1 ? w_rs1_fld : 5'd0;
    assign w_rs2_idx = w_use_rs2 ? w_rs2_fld : 5'd0;

    decode_stage_reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .rs1_idx_i (w_rs1_idx),
        .rs2_idx_i (w_rs2_idx),
        .rs1_val_o (w_rs1_val),
        .rs2_val_o (w_rs2_val),
        .we_i      (wb_we),
        .wr_idx_i  (wb_rd),
        .wr_data_i (wb_data)
    );

    // Opcode decode and immediate generation into a candidate bundle
    always_comb begin
        w_dec = '0;
        if (!w_bubble) begin
            w_dec.valid   = 1'b1;
            w_dec.pc      = pc_de;
            w_dec.funct3  = w_funct3;
            w_dec.rs1     = w_rs1_idx;
            w_dec.rs2     = w_rs2_idx;
            w_dec.rs1_val = w_rs1_val;
            w_dec.rs2_val = w_rs2_val;
            w_dec.alu_op  = c_alu_add;
            case (w_opcode)
                c_op_lui: begin
                    w_dec.imm    = {instr_d[31:12], 12'b0};
                    w_dec.alu_op = c_alu_passb;
                    w_dec.ctrl[c_ctrl_src_imm] = 1'b1;
                    w_dec.ctrl[c_ctrl_reg_wr]  = 1'b1;
                end
                c_op_auipc: begin
                    w_dec.imm = {instr_d[31:12], 12'b0};
                    w_dec.ctrl[c_ctrl_src_imm] = 1'b1;
                    w_dec.ctrl[c_ctrl_reg_wr]  = 1'b1;
                end
                c_op_jal: begin
                    w_dec.imm = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                                 instr_d[20], instr_d[30:21], 1'b0};
                    w_dec.ctrl[c_ctrl_reg_wr] = 1'b1;
                    w_dec.ctrl[c_ctrl_jump]   = 1'b1;
                end
                c_op_jalr: begin
                    w_dec.imm = {{20{instr_d[31]}}, instr_d[31:20]};
                    w_dec.ctrl[c_ctrl_src_imm] = 1'b1;
                    w_dec.ctrl[c_ctrl_reg_wr]  = 1'b1;
                    w_dec.ctrl[c_ctrl_jump]    = 1'b1;
                end
                c_op_branch: begin
                    w_dec.imm = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                                 instr_d[30:25], instr_d[11:8], 1'b0};
                    w_dec.alu_op = c_alu_sub;
                    w_dec.ctrl[c_ctrl_branch] = 1'b1;
                end
                c_op_load: begin
                    w_dec.imm = {{20{instr_d[31]}}, instr_d[31:20]};
                    w_dec.ctrl[c_ctrl_src_imm] = 1'b1;
                    w_dec.ctrl[c_ctrl_mem_rd]  = 1'b1;
                    w_dec.ctrl[c_ctrl_reg_wr]  = 1'b1;
                end
                c_op_store: begin
                    w_dec.imm = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
                    w_dec.ctrl[c_ctrl_src_imm] = 1'b1;
                    w_dec.ctrl[c_ctrl_mem_wr]  = 1'b1;
                end
                c_op_opimm: begin
                    w_dec.imm    = {{20{instr_d[31]}}, instr_d[31:20]};
                    w_dec.alu_op = alu_op_decode(w_funct3, instr_d[30], 1'b0);
                    w_dec.ctrl[c_ctrl_src_imm] = 1'b1;
                    w_dec.ctrl[c_ctrl_reg_wr]  = 1'b1;
                end
                c_op_op: begin
                    w_dec.alu_op = alu_op_decode(w_funct3, instr_d[30], 1'b1);
                    w_dec.ctrl[c_ctrl_reg_wr] = 1'b1;
                end
                // FENCE / SYSTEM pass through as valid no-ops
                c_op_misc_mem, c_op_system: ;
                default: w_dec.ctrl[c_ctrl_illegal] = 1'b1;
            endcase
            // rd is only meaningful when the instruction writes back
            w_dec.rd = w_dec.ctrl[c_ctrl_reg_wr] ? w_rd_fld : 5'd0;
        end
    end

    // Load in execute whose destination is a source of the incoming instruction
    assign w_load_use = r_bundle_q.valid
                     && r_bundle_q.ctrl[c_ctrl_mem_rd]
                     && (r_bundle_q.rd != 5'd0)
                     && ((w_use_rs1 && (w_rs1_fld == r_bundle_q.rd))
                      || (w_use_rs2 && (w_rs2_fld == r_bundle_q.rd)));

    // Next state / next bundle: flush > ex_stall > squash > load-use > issue
    always_comb begin
        r_state_d  = r_state_q;
        r_bundle_d = r_bundle_q;
        w_stall_f  = 1'b0;
        if (flush) begin
            r_bundle_d = '0;
            r_state_d  = ST_SQUASH;
        end else if (ex_stall) begin
            w_stall_f = 1'b1;
        end else if (r_state_q == ST_SQUASH) begin
            r_bundle_d = '0;
            r_state_d  = ST_RUN;
        end else if (w_load_use) begin
            w_stall_f  = 1'b1;
            r_bundle_d = '0;
        end else begin
            r_bundle_d = w_dec;
        end
    end

    // Stall request is suppressed while reset is held
    assign stall_f = rst & w_stall_f;

    // State and bundle registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q  <= ST_RUN;
            r_bundle_q <= '0;
        end else begin
            r_state_q  <= r_state_d;
            r_bundle_q <= r_bundle_d;
        end
    end

    assign ex_valid   = r_bundle_q.valid;
    assign ex_pc      = r_bundle_q.pc;
    assign ex_rs1_val = r_bundle_q.rs1_val;
    assign ex_rs2_val = r_bundle_q.rs2_val;
    assign ex_imm     = r_bundle_q.imm;
    assign ex_rs1     = r_bundle_q.rs1;
    assign ex_rs2     = r_bundle_q.rs2;
    assign ex_rd      = r_bundle_q.rd;
    assign ex_alu_op  = r_bundle_q.alu_op;
    assign ex_funct3  = r_bundle_q.funct3;
    assign ex_ctrl    = r_bundle_q.ctrl;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Scoreboard bench for decode_stage with directed RV32I vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d, pc_de, wb_data;
    logic        flush, ex_stall, wb_we;
    logic [4:0]  wb_rd;
    logic        stall_f, ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_ctrl;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .instr_d    (instr_d),
        .pc_de      (pc_de),
        .flush      (flush),
        .ex_stall   (ex_stall),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .stall_f    (stall_f),
        .ex_valid   (ex_valid),
        .ex_pc      (ex_pc),
        .ex_rs1_val (ex_rs1_val),
        .ex_rs2_val (ex_rs2_val),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .ex_alu_op  (ex_alu_op),
        .ex_funct3  (ex_funct3),
        .ex_ctrl    (ex_ctrl)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [6:0]  ctrl;
    } exp_t;

    localparam exp_t BUBBLE = '0;

    localparam logic [31:0] I_ADDI   = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_LW     = 32'h0000A103; // lw   x2,0(x1)
    localparam logic [31:0] I_ADD    = 32'h002101B3; // add  x3,x2,x2
    localparam logic [31:0] I_BEQ    = 32'h00208463; // beq  x1,x2,+8
    localparam logic [31:0] I_ADD65  = 32'h00028333; // add  x6,x5,x0
    localparam logic [31:0] I_ADD600 = 32'h00000333; // add  x6,x0,x0
    localparam logic [31:0] I_ILL    = 32'hFFFFFFFF; // unknown opcode
    localparam logic [31:0] I_JAL    = 32'h010000EF; // jal  x1,+16

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] BYP_X5 = 32'hDEADBEEF;
`else
    localparam logic [31:0] BYP_X5 = 32'h0;
`endif

    exp_t sb_q[$];
    exp_t mon_e, mon_a;
    int   n_total = 0;
    int   n_bad   = 0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] v1,
                                input logic [4:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [3:0] alu, input logic [2:0] f3,
                                input logic [6:0] ctrl);
        exp_t e;
        e = '{valid: 1'b1, pc: pc, rs1_val: v1, rs2_val: v2, imm: imm,
              rs1: rs1, rs2: rs2, rd: rd, alu: alu, f3: f3, ctrl: ctrl};
        return e;
    endfunction

    function automatic exp_t e_addi(input logic [31:0] pc);
        return mk(pc, 5'd0, 32'h0, 5'd0, 32'h0, 32'd5, 5'd1, 4'd0, 3'd0, 7'h48);
    endfunction
    function automatic exp_t e_lw(input logic [31:0] pc, input logic [31:0] x1);
        return mk(pc, 5'd1, x1, 5'd0, 32'h0, 32'd0, 5'd2, 4'd0, 3'd2, 7'h68);
    endfunction
    function automatic exp_t e_add(input logic [31:0] pc);
        return mk(pc, 5'd2, 32'h55, 5'd2, 32'h55, 32'd0, 5'd3, 4'd0, 3'd0, 7'h08);
    endfunction
    function automatic exp_t e_add65(input logic [31:0] pc, input logic [31:0] x5);
        return mk(pc, 5'd5, x5, 5'd0, 32'h0, 32'd0, 5'd6, 4'd0, 3'd0, 7'h08);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compare each registered bundle against the oldest expectation
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_a = {ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2,
                     ex_rd, ex_alu_op, ex_funct3, ex_ctrl};
            n_total++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL bundle: got v=%b pc=%h r1v=%h r2v=%h imm=%h r1=%0d r2=%0d rd=%0d alu=%0d f3=%0d ctrl=%h want v=%b pc=%h r1v=%h r2v=%h imm=%h r1=%0d r2=%0d rd=%0d alu=%0d f3=%0d ctrl=%h",
                         mon_a.valid, mon_a.pc, mon_a.rs1_val, mon_a.rs2_val, mon_a.imm, mon_a.rs1, mon_a.rs2,
                         mon_a.rd, mon_a.alu, mon_a.f3, mon_a.ctrl,
                         mon_e.valid, mon_e.pc, mon_e.rs1_val, mon_e.rs2_val, mon_e.imm, mon_e.rs1, mon_e.rs2,
                         mon_e.rd, mon_e.alu, mon_e.f3, mon_e.ctrl);
            end
        end
    end

    // One decode cycle: drive inputs, check stall_f, queue the bundle expected after the edge
    task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic fl, input logic st,
                        input logic we, input logic [4:0] rd, input logic [31:0] data,
                        input logic exp_stall, input exp_t exp);
        @(negedge clk);
        instr_d  = instr;
        pc_de    = pc;
        flush    = fl;
        ex_stall = st;
        wb_we    = we;
        wb_rd    = rd;
        wb_data  = data;
        #1;
        check($sformatf("stall_f pc=%h", pc), {31'b0, stall_f}, {31'b0, exp_stall});
        sb_q.push_back(exp);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        check("scoreboard drained", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic idle_inputs();
        instr_d = '0; pc_de = '0; flush = 1'b0; ex_stall = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    // Assert reset asynchronously mid-cycle, then release at the next falling edge
    task automatic reset_mid(input string name);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check({name, " ex_valid"}, {31'b0, ex_valid}, 32'h0);
        check({name, " ex_rd"}, {27'b0, ex_rd}, 32'h0);
        check({name, " stall_f"}, {31'b0, stall_f}, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset ex_valid", {31'b0, ex_valid}, 32'h0);
        check("reset stall_f", {31'b0, stall_f}, 32'h0);
        check("reset ex_pc", ex_pc, 32'h0);
        check("reset ex_ctrl", {25'b0, ex_ctrl}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        //   instr     pc     fl    st    we    rd    data          stall exp
        step(32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, BUBBLE);
        step(I_ADDI,   32'h8, 1'b0, 1'b0, 1'b1, 5'd1, 32'h100,      1'b0, e_addi(32'h8));
        step(I_LW,     32'hC, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_lw(32'hC, 32'h100));
        step(I_ADD,    32'h10,1'b0, 1'b0, 1'b1, 5'd2, 32'h55,       1'b1, BUBBLE);
        step(I_ADD,    32'h10,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_add(32'h10));
        step(I_BEQ,    32'h14,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0,
             mk(32'h14, 5'd1, 32'h100, 5'd2, 32'h55, 32'd8, 5'd0, 4'd1, 3'd0, 7'h04));
        // redirect: two wrong-path instructions squashed, third issues
        step(I_ADDI,   32'h18,1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, BUBBLE);
        step(I_ADD,    32'h1C,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, BUBBLE);
        step(I_ADDI,   32'h20,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_addi(32'h20));
        // execute stall for three cycles holds the load, then load-use
        step(I_LW,     32'h24,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_lw(32'h24, 32'h100));
        for (int i = 0; i < 3; i++)
            step(I_ADD, 32'h28,1'b0, 1'b1, 1'b0, 5'd0, 32'h0,       1'b1, e_lw(32'h24, 32'h100));
        step(I_ADD,    32'h28,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, BUBBLE);
        step(I_ADD,    32'h28,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_add(32'h28));
        // flush beats ex_stall; stall in SQUASH keeps the squash pending
        step(I_ADDI,   32'h2C,1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, BUBBLE);
        step(I_LW,     32'h30,1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, BUBBLE);
        step(I_LW,     32'h30,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, BUBBLE);
        step(I_ADDI,   32'h34,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_addi(32'h34));
        // WB collision, x0 write ignored
        step(I_ADD65,  32'h38,1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, e_add65(32'h38, BYP_X5));
        step(I_ADD65,  32'h3C,1'b0, 1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, e_add65(32'h3C, 32'hDEADBEEF));
        step(I_ADD600, 32'h40,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0,
             mk(32'h40, 5'd0, 32'h0, 5'd0, 32'h0, 32'd0, 5'd6, 4'd0, 3'd0, 7'h08));
        step(I_ILL,    32'h44,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0,
             mk(32'h44, 5'd0, 32'h0, 5'd0, 32'h0, 32'd0, 5'd0, 4'd0, 3'd7, 7'h01));
        step(I_JAL,    32'h48,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0,
             mk(32'h48, 5'd0, 32'h0, 5'd0, 32'h0, 32'd16, 5'd1, 4'd0, 3'd0, 7'h0A));
        step(I_LW,     32'h4C,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_lw(32'h4C, 32'h100));
        // bubble behind a load is not a hazard source
        step(32'h0,    32'h50,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, BUBBLE);
        // async reset while execute stall holds a valid load
        step(I_LW,     32'h54,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_lw(32'h54, 32'h100));
        step(I_ADD,    32'h58,1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, e_lw(32'h54, 32'h100));
        drain();
        reset_mid("rst mid-stall");
        // register file cleared by reset
        step(I_LW,     32'h5C,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_lw(32'h5C, 32'h0));
        // flush wins over a pending load-use
        step(I_ADD,    32'h60,1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, BUBBLE);
        drain();
        reset_mid("rst mid-squash");
        step(I_ADDI,   32'h64,1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, e_addi(32'h64));
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
